addf_arb: RTL and testbench

Round-robin scheduler that shares one single-precision float adder (`addf`, combinational, instantiated inside this block) among N requesters. Each requester presents an operand pair through a valid/ready handshake. The block grants one requester at a time, registers the operands, and registers the adder result. It returns the sum with the requester's index on a shared response channel that supports backpressure. It sits between the float-unit clients and the `addf` datapath.

---
 rtl/addf_arb.sv | 225 ++++++++++++++++++++++
 tb/tb_addf_arb.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/addf_arb.sv
// Round-robin arbiter sharing one combinational single-precision adder among N requesters.
// Contains the truncating adder (addf) and the scheduler top (addf_arb).

module addf (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] s_o
);

  // Count of leading zeros in a 24-bit mantissa (24 when all zero).
  function automatic logic [4:0] lzc24(input logic [23:0] m);
    logic [4:0] n;
    n = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (m[i]) begin
        n = 5'(23 - i);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  logic [31:0] big_s;
  logic [31:0] small_s;
  logic [7:0]  exp_big_s;
  logic [7:0]  exp_diff_s;
  logic [23:0] man_big_s;
  logic [23:0] man_small_s;
  logic [24:0] sum_s;
  logic [23:0] diff_s;
  logic [23:0] norm_s;
  logic [4:0]  lz_s;

  // Align the smaller operand, add or subtract magnitudes, renormalise with truncation.
  always_comb begin
    big_s       = (a_i[30:0] >= b_i[30:0]) ? a_i : b_i;
    small_s     = (a_i[30:0] >= b_i[30:0]) ? b_i : a_i;
    exp_big_s   = big_s[30:23];
    exp_diff_s  = big_s[30:23] - small_s[30:23];
    man_big_s   = {1'b1, big_s[22:0]};
    man_small_s = {1'b1, small_s[22:0]} >> exp_diff_s;
    sum_s       = 25'd0;
    diff_s      = 24'd0;
    norm_s      = 24'd0;
    lz_s        = 5'd0;
    s_o         = 32'd0;
    if (big_s[31] == small_s[31]) begin
      sum_s = {1'b0, man_big_s} + {1'b0, man_small_s};
      if (sum_s[24]) begin
        s_o = {big_s[31], exp_big_s + 8'd1, sum_s[23:1]};
      end else begin
        s_o = {big_s[31], exp_big_s, sum_s[22:0]};
      end
    end else begin
      diff_s = man_big_s - man_small_s;
      lz_s   = lzc24(diff_s);
      norm_s = diff_s << lz_s;
      if (diff_s == 24'd0) begin
        s_o = 32'd0;
      end else begin
        s_o = {big_s[31], exp_big_s - {3'd0, lz_s}, norm_s[22:0]};
      end
    end
  end

endmodule

module addf_arb #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req_valid,
  input  logic [32*N-1:0]   req_a,
  input  logic [32*N-1:0]   req_b,
  output logic [N-1:0]      req_ready,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_s,
  input  logic              rsp_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e         state_q;
  state_e         state_d;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;
  logic [IDW-1:0] id_q;
  logic [31:0]    op_a_q;
  logic [31:0]    op_b_q;
  logic           rsp_valid_q;
  logic [IDW-1:0] rsp_id_q;
  logic [31:0]    rsp_s_q;
  logic           grant_vld_s;
  logic [IDW-1:0] grant_idx_s;
  logic [31:0]    sum_s;

  addf u_addf (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .s_o (sum_s)
  );

  // Rotating priority search starting at ptr_q, wrapping at N.
  always_comb begin
    int idx;
    idx         = 0;
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N) begin
        idx = idx - N;
      end else begin
        idx = idx;
      end
      if (!grant_vld_s && req_valid[idx]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = IDW'(idx);
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // Pointer following the winner; explicit wrap keeps non-power-of-2 N in range.
  always_comb begin
    if (grant_idx_s == IDW'(N - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = grant_idx_s + IDW'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_vld_s) begin
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: state_d = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant strobe; gated by rst_n so it reads zero while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == IDLE) && grant_vld_s) begin
      req_ready[grant_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Operand capture, pointer update and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      id_q        <= '0;
      op_a_q      <= 32'd0;
      op_b_q      <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_s_q     <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld_s) begin
            op_a_q <= req_a[int'(grant_idx_s)*32 +: 32];
            op_b_q <= req_b[int'(grant_idx_s)*32 +: 32];
            id_q   <= grant_idx_s;
            ptr_q  <= ptr_d;
          end
        end
        CALC: begin
          rsp_s_q     <= sum_s;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
          end
        end
        default: rsp_valid_q <= 1'b0;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_s     = rsp_s_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_addf_arb.sv
// Directed bench for addf_arb: a 4-requester instance and a 3-requester instance for pointer wrap.

module tb_addf_arb;

  logic          clk;
  logic          rst_n;
  logic [3:0]    req_valid;
  logic [127:0]  req_a;
  logic [127:0]  req_b;
  logic [3:0]    req_ready;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [31:0]   rsp_s;
  logic          rsp_ready;
  logic          busy;

  logic [2:0]    v3;
  logic [95:0]   a3;
  logic [95:0]   b3;
  logic [2:0]    rdy3;
  logic          rv3;
  logic [1:0]    id3;
  logic [31:0]   s3;
  logic          rr3;
  logic          busy3;

  int checks;
  int failures;

  addf_arb #(.N(4), .IDW(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_s     (rsp_s),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  addf_arb #(.N(3), .IDW(2)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (v3),
    .req_a     (a3),
    .req_b     (b3),
    .req_ready (rdy3),
    .rsp_valid (rv3),
    .rsp_id    (id3),
    .rsp_s     (s3),
    .rsp_ready (rr3),
    .busy      (busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // One isolated add on the 4-requester instance, starting just after a rising edge.
  task automatic add4(input int k, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_s);
    req_valid = 4'd0;
    req_valid[k] = 1'b1;
    req_a[32*k +: 32] = a;
    req_b[32*k +: 32] = b;
    rsp_ready = 1'b1;
    @(negedge clk); chk("add_rdy", 32'(req_ready), 32'(1 << k));
    @(posedge clk); #1; req_valid = 4'd0;
    @(negedge clk); chk("add_busy", 32'(busy), 32'd1); chk("add_rv_T1", 32'(rsp_valid), 32'd0);
    @(negedge clk); chk("add_rv", 32'(rsp_valid), 32'd1);
    chk("add_id", 32'(rsp_id), 32'(k)); chk("add_s", rsp_s, exp_s);
    @(posedge clk); #1;
    @(negedge clk); chk("add_idle", 32'(busy), 32'd0); chk("add_rv_T3", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  // Same flow on the 3-requester instance.
  task automatic add3(input int k, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_s);
    v3 = 3'd0;
    v3[k] = 1'b1;
    a3[32*k +: 32] = a;
    b3[32*k +: 32] = b;
    @(negedge clk); chk("n3_rdy", 32'(rdy3), 32'(1 << k));
    @(posedge clk); #1; v3 = 3'd0;
    @(negedge clk);
    @(negedge clk); chk("n3_id", 32'(id3), 32'(k)); chk("n3_s", s3, exp_s);
    @(posedge clk); #1;
  endtask

  logic [31:0] fa [4];
  logic [31:0] fb [4];
  logic [31:0] fs [4];

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    req_valid = 4'b1111; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    v3 = 3'd0; a3 = '0; b3 = '0; rr3 = 1'b1;
    fa[0] = 32'h3F800000; fb[0] = 32'h3F800000; fs[0] = 32'h40000000;
    fa[1] = 32'h40000000; fb[1] = 32'h3F800000; fs[1] = 32'h40400000;
    fa[2] = 32'h3FC00000; fb[2] = 32'hBFC00000; fs[2] = 32'h00000000;
    fa[3] = 32'hC0400000; fb[3] = 32'h3F800000; fs[3] = 32'hC0000000;

    #12;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rv", 32'(rsp_valid), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_s", rsp_s, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    req_valid = 4'd0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Single add and arithmetic vectors
    add4(1, 32'h3F800000, 32'h3F800000, 32'h40000000);
    add4(0, 32'h40000000, 32'h3F800000, 32'h40400000);
    add4(2, 32'h3FC00000, 32'hBFC00000, 32'h00000000);
    add4(3, 32'hC0400000, 32'h3F800000, 32'hC0000000);

    // Fairness: all requesters held valid for 12 grants, ptr starts at 0
    for (int k = 0; k < 4; k++) begin
      req_a[32*k +: 32] = fa[k];
      req_b[32*k +: 32] = fb[k];
    end
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int g = 0; g < 12; g++) begin
      @(negedge clk); chk("rr_grant", 32'(req_ready), 32'(1 << (g % 4)));
      @(posedge clk); #1;
      @(negedge clk); chk("rr_ready_calc", 32'(req_ready), 32'd0);
      @(negedge clk); chk("rr_id", 32'(rsp_id), 32'(g % 4)); chk("rr_s", rsp_s, fs[g % 4]);
      @(posedge clk); #1;
    end

    // Backpressure: req0 granted, req2 pending, rsp_ready low for 5 RESP cycles
    req_a[31:0] = 32'h40000000; req_b[31:0] = 32'h3F800000;
    req_a[95:64] = 32'hC0400000; req_b[95:64] = 32'h3F800000;
    req_valid = 4'b0101; rsp_ready = 1'b0;
    @(negedge clk); chk("bp_grant0", 32'(req_ready), 32'h1);
    @(posedge clk); #1; req_valid = 4'b0100;
    @(negedge clk); chk("bp_calc_rdy", 32'(req_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_rv", 32'(rsp_valid), 32'd1);
      chk("bp_id", 32'(rsp_id), 32'd0);
      chk("bp_s", rsp_s, 32'h40400000);
      chk("bp_rdy", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk); chk("bp_hold", 32'(rsp_valid), 32'd1); chk("bp_hold_s", rsp_s, 32'h40400000);
    @(posedge clk); #1;
    @(negedge clk); chk("bp_next_grant", 32'(req_ready), 32'h4); chk("bp_rv_drop", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1; req_valid = 4'd0;
    @(negedge clk);
    @(negedge clk); chk("bp2_id", 32'(rsp_id), 32'd2); chk("bp2_s", rsp_s, 32'hC0000000);
    @(posedge clk); #1;

    // Withdrawn request: ptr=3, valid {0,1,3}; req1 drops out before its turn
    req_a[127:96] = 32'h3F800000; req_b[127:96] = 32'h3F800000;
    req_a[31:0] = 32'h3FC00000; req_b[31:0] = 32'h3F800000;
    req_a[63:32] = 32'h41000000; req_b[63:32] = 32'h41000000;
    req_valid = 4'b1011;
    @(negedge clk); chk("wd_grant3", 32'(req_ready), 32'h8);
    @(posedge clk); #1; req_valid = 4'b0001;
    @(negedge clk);
    @(negedge clk); chk("wd_id3", 32'(rsp_id), 32'd3); chk("wd_s3", rsp_s, 32'h40000000);
    @(posedge clk); #1;
    @(negedge clk); chk("wd_grant0", 32'(req_ready), 32'h1);
    @(posedge clk); #1; req_valid = 4'd0;
    @(negedge clk);
    @(negedge clk); chk("wd_id0", 32'(rsp_id), 32'd0); chk("wd_s0", rsp_s, 32'h40200000);
    @(posedge clk); #1;
    @(negedge clk); chk("wd_none", 32'(req_ready), 32'd0); chk("wd_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Reset while a response is held in RESP
    req_a[63:32] = 32'h3F800000; req_b[63:32] = 32'h3F800000;
    req_valid = 4'b0010; rsp_ready = 1'b0;
    @(negedge clk); chk("mr_grant1", 32'(req_ready), 32'h2);
    @(posedge clk); #1; req_valid = 4'b1111;
    @(negedge clk);
    @(negedge clk); chk("mr_rv_pre", 32'(rsp_valid), 32'd1);
    #2; rst_n = 1'b0;
    #1;
    chk("mr_rv", 32'(rsp_valid), 32'd0);
    chk("mr_s", rsp_s, 32'd0);
    chk("mr_id", 32'(rsp_id), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_ready", 32'(req_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1; rsp_ready = 1'b1;
    #1; chk("mr_restart_ptr0", 32'(req_ready), 32'h1); chk("mr_no_stale", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1; req_valid = 4'd0;
    @(negedge clk); chk("mr_no_stale2", 32'(rsp_valid), 32'd0);
    @(negedge clk); chk("mr_rv_new", 32'(rsp_valid), 32'd1);
    chk("mr_id_new", 32'(rsp_id), 32'd0); chk("mr_s_new", rsp_s, 32'h40200000);
    @(posedge clk); #1;

    // N=3: advance ptr to 2, then valid {0,2} grants 2 then wraps to 0
    add3(0, 32'h3F800000, 32'h3F800000, 32'h40000000);
    add3(1, 32'h40000000, 32'h3F800000, 32'h40400000);
    a3[31:0] = 32'h40000000; b3[31:0] = 32'h3F800000;
    a3[95:64] = 32'h3F800000; b3[95:64] = 32'h3F800000;
    v3 = 3'b101;
    @(negedge clk); chk("n3_wrap_g2", 32'(rdy3), 32'h4);
    @(posedge clk); #1; v3 = 3'b001;
    @(negedge clk);
    @(negedge clk); chk("n3_wrap_id2", 32'(id3), 32'd2); chk("n3_wrap_s2", s3, 32'h40000000);
    @(posedge clk); #1;
    @(negedge clk); chk("n3_wrap_g0", 32'(rdy3), 32'h1);
    @(posedge clk); #1; v3 = 3'd0;
    @(negedge clk);
    @(negedge clk); chk("n3_wrap_id0", 32'(id3), 32'd0); chk("n3_wrap_s0", s3, 32'h40400000);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
